// File: rtl/sdram_cmd_pkg.sv
// Shared types and encodings for the per-channel SDRAM command sequencer.
// Commands are packed as {cs_, ras_, cas_, we_}, all active-low.
package sdram_cmd_pkg;

    localparam int ADRS_W = 12;
    localparam int BA_W   = 2;
    localparam int COL_W  = 9;
    localparam int BE_W   = 8;
    localparam int A10    = 10;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_INIT_PRE,
        ST_INIT_REF1,
        ST_INIT_REF2,
        ST_INIT_MRS,
        ST_IDLE,
        ST_ACT,
        ST_RW,
        ST_PRE,
        ST_REF,
        ST_WAIT
    } state_t;

    // Request fields held from acceptance until the column command is issued.
    typedef struct packed {
        logic             write;
        logic [BA_W-1:0]  bank;
        logic [COL_W-1:0] col;
        logic [BE_W-1:0]  be;
    } req_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval timer: free-running down-counter once enabled, with a
// sticky pending flag that the sequencer clears when it issues REF.
module sdram_refresh_timer
    import sdram_cmd_pkg::*;
#(
    parameter int T_REF = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic ref_pending,
    output logic ref_due
);

    localparam int RW = (T_REF > 2) ? $clog2(T_REF) : 1;

    logic [RW-1:0] cnt;

    // Counter is at zero this cycle; pending becomes visible next cycle.
    assign ref_due = enable && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= RW'(T_REF - 1);
            ref_pending <= 1'b0;
        end else begin
            if (!enable || ref_due)
                cnt <= RW'(T_REF - 1);
            else
                cnt <= cnt - RW'(1);

            if (ref_due)
                ref_pending <= 1'b1;
            else if (clear)
                ref_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_cmd_seq.sv
// Closed-page SDRAM command sequencer for one channel: power-up init,
// single-beat read/write as ACT -> RD/WR -> PRE-all, and periodic auto-refresh.
module sdram_cmd_seq
    import sdram_cmd_pkg::*;
#(
    parameter int               T_INIT   = 200,
    parameter int               T_RCD    = 2,
    parameter int               T_RP     = 2,
    parameter int               T_RFC    = 7,
    parameter int               T_WR     = 2,
    parameter int               CAS_LAT  = 2,
    parameter int               T_REF    = 780,
    parameter logic [ADRS_W-1:0] MODE_REG = 12'h022
) (
    input  logic              sd_clk,
    input  logic              sd_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [BA_W-1:0]   req_bank,
    input  logic [ADRS_W-1:0] req_row,
    input  logic [COL_W-1:0]  req_col,
    input  logic [BE_W-1:0]   req_be,
    output logic              init_done,
    output logic              rd_valid,
    output logic [ADRS_W-1:0] c0_sd_adrs,
    output logic [BA_W-1:0]   c0_sd_ba,
    output logic [BE_W-1:0]   c0_sd_dqm_,
    output logic              sd_cs_,
    output logic              sd_ras_,
    output logic              sd_cas_,
    output logic              sd_we_
);

    localparam int CW = $clog2(T_INIT + T_RFC + T_RCD + T_WR + T_RP + 2);

    state_t            state, nxt_state, ret, nxt_ret;
    logic [CW-1:0]     cnt, nxt_cnt;
    req_t              rq;
    logic              accept;
    logic              leave;
    int                gap;
    state_t            tgt;

    logic [3:0]        cmd_q, nxt_cmd;
    logic [ADRS_W-1:0] nxt_adrs;
    logic [BA_W-1:0]   nxt_ba;
    logic [BE_W-1:0]   nxt_dqm;
    logic              nxt_ready, nxt_init_done;
    logic [CAS_LAT-1:0] rd_pipe;

    logic ref_pending, ref_due, ref_clear;

    // Gaps of one go straight to the target; longer gaps park in WAIT,
    // which hands over to the target when its counter hits zero.
    function automatic state_t gap_state(input int t, input state_t s);
        return (t <= 1) ? s : ST_WAIT;
    endfunction

    function automatic logic [CW-1:0] gap_cnt(input int t);
        return (t >= 2) ? CW'(t - 2) : '0;
    endfunction

    sdram_refresh_timer #(
        .T_REF(T_REF)
    ) u_ref (
        .clk        (sd_clk),
        .rst        (sd_rst),
        .enable     (init_done),
        .clear      (ref_clear),
        .ref_pending(ref_pending),
        .ref_due    (ref_due)
    );

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_ret   = ret;
        accept    = 1'b0;
        leave     = 1'b0;
        gap       = 1;
        tgt       = ST_IDLE;

        case (state)
            ST_INIT_WAIT: begin
                if (cnt == '0) nxt_state = ST_INIT_PRE;
                else           nxt_cnt   = cnt - CW'(1);
            end
            ST_INIT_PRE:  begin leave = 1'b1; gap = T_RP;  tgt = ST_INIT_REF1; end
            ST_INIT_REF1: begin leave = 1'b1; gap = T_RFC; tgt = ST_INIT_REF2; end
            ST_INIT_REF2: begin leave = 1'b1; gap = T_RFC; tgt = ST_INIT_MRS;  end
            ST_INIT_MRS:  begin leave = 1'b1; gap = 2;     tgt = ST_IDLE;      end
            ST_IDLE: begin
                if (ref_pending) begin
                    nxt_state = ST_REF;
                end else if (req_valid && req_ready) begin
                    accept    = 1'b1;
                    nxt_state = ST_ACT;
                end
            end
            ST_ACT: begin leave = 1'b1; gap = T_RCD; tgt = ST_RW; end
            ST_RW:  begin leave = 1'b1; gap = rq.write ? T_WR : 1; tgt = ST_PRE; end
            ST_PRE: begin leave = 1'b1; gap = T_RP;  tgt = ST_IDLE; end
            ST_REF: begin leave = 1'b1; gap = T_RFC; tgt = ST_IDLE; end
            ST_WAIT: begin
                if (cnt == '0) nxt_state = ret;
                else           nxt_cnt   = cnt - CW'(1);
            end
            default: nxt_state = ST_INIT_WAIT;
        endcase

        if (leave) begin
            nxt_state = gap_state(gap, tgt);
            nxt_cnt   = gap_cnt(gap);
            nxt_ret   = tgt;
        end
    end

    // Pin values are decoded from the state being entered, so the command
    // appears in the same cycle the FSM occupies its command state.
    always_comb begin
        nxt_cmd  = CMD_NOP;
        nxt_adrs = '0;
        nxt_ba   = '0;
        nxt_dqm  = '1;
        case (nxt_state)
            ST_INIT_PRE, ST_PRE: begin
                nxt_cmd       = CMD_PRE;
                nxt_adrs[A10] = 1'b1;
            end
            ST_INIT_REF1, ST_INIT_REF2, ST_REF: nxt_cmd = CMD_REF;
            ST_INIT_MRS: begin
                nxt_cmd  = CMD_MRS;
                nxt_adrs = MODE_REG;
            end
            ST_ACT: begin
                nxt_cmd  = CMD_ACT;
                nxt_adrs = req_row;
                nxt_ba   = req_bank;
            end
            ST_RW: begin
                nxt_cmd  = rq.write ? CMD_WRITE : CMD_READ;
                nxt_adrs = {{(ADRS_W - COL_W){1'b0}}, rq.col};
                nxt_ba   = rq.bank;
                nxt_dqm  = ~rq.be;
            end
            default: ;
        endcase
    end

    assign ref_clear     = (nxt_state == ST_REF);
    assign nxt_init_done = init_done || (nxt_state == ST_IDLE);
    // Hold off requests one cycle early when the refresh counter is expiring.
    assign nxt_ready     = (nxt_state == ST_IDLE) && !ref_pending && !ref_due;

    always_ff @(posedge sd_clk) begin
        if (sd_rst) begin
            state      <= ST_INIT_WAIT;
            cnt        <= CW'(T_INIT - 1);
            ret        <= ST_IDLE;
            rq         <= '0;
            cmd_q      <= CMD_NOP;
            c0_sd_adrs <= '0;
            c0_sd_ba   <= '0;
            c0_sd_dqm_ <= '1;
            req_ready  <= 1'b0;
            init_done  <= 1'b0;
            rd_pipe    <= '0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            ret        <= nxt_ret;
            if (accept)
                rq <= {req_write, req_bank, req_col, req_be};
            cmd_q      <= nxt_cmd;
            c0_sd_adrs <= nxt_adrs;
            c0_sd_ba   <= nxt_ba;
            c0_sd_dqm_ <= nxt_dqm;
            req_ready  <= nxt_ready;
            init_done  <= nxt_init_done;
            rd_pipe[0] <= (cmd_q == CMD_READ);
            for (int i = 1; i < CAS_LAT; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign {sd_cs_, sd_ras_, sd_cas_, sd_we_} = cmd_q;
    assign rd_valid = rd_pipe[CAS_LAT-1];

endmodule
